// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-back write-allocate cache controller
module dm_cache_ctrl #(
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int INDEX_WIDTH      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_read,
  input  logic                        cpu_write,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [DATA_WIDTH-1:0]       cpu_wdata,
  output logic                        stall,
  output logic                        hit,
  output logic [CACHE_LINE_WIDTH-1:0] line_out,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [CACHE_LINE_WIDTH-1:0] mem_wdata,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_rdata,
  input  logic                        mem_ready
);

  localparam int NUM_LINES = 2 ** INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int WORDS     = CACHE_LINE_WIDTH / DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t state;

  // Line storage: one entry per index, valid/dirty kept as flat bit vectors.
  logic [NUM_LINES-1:0]        valid_arr;
  logic [NUM_LINES-1:0]        dirty_arr;
  logic [TAG_WIDTH-1:0]        tag_arr  [NUM_LINES];
  logic [CACHE_LINE_WIDTH-1:0] data_arr [NUM_LINES];

  // Request fields decoded from the CPU word address.
  logic                   req;
  logic [1:0]             cpu_off;
  logic [INDEX_WIDTH-1:0] cpu_idx;
  logic [TAG_WIDTH-1:0]   cpu_tag;

  // Index/tag captured when a miss leaves IDLE; the refill always targets these.
  logic [INDEX_WIDTH-1:0] lat_idx;
  logic [TAG_WIDTH-1:0]   lat_tag;

  assign req     = cpu_read | cpu_write;
  assign cpu_off = cpu_addr[1:0];
  assign cpu_idx = cpu_addr[INDEX_WIDTH+1:2];
  assign cpu_tag = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];

  // Lookup path is purely combinational so read hits complete with zero latency.
  always_comb begin
    hit      = req & valid_arr[cpu_idx] & (tag_arr[cpu_idx] == cpu_tag);
    line_out = data_arr[cpu_idx];
    stall    = (state != S_IDLE) | (req & ~hit);
  end

  // Controller FSM with registered memory-side outputs and all array updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      valid_arr <= '0;
      dirty_arr <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_arr[i]  <= '0;
        data_arr[i] <= '0;
      end
      lat_idx   <= '0;
      lat_tag   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              // A simultaneous read+write request is treated as a store.
              if (cpu_write) begin
                for (int w = 0; w < WORDS; w++) begin
                  if (cpu_off == w[1:0]) begin
                    data_arr[cpu_idx][w*DATA_WIDTH +: DATA_WIDTH] <= cpu_wdata;
                  end
                end
                dirty_arr[cpu_idx] <= 1'b1;
              end
            end else begin
              lat_idx <= cpu_idx;
              lat_tag <= cpu_tag;
              if (valid_arr[cpu_idx] && dirty_arr[cpu_idx]) begin
                // Victim is modified: push it out before refilling.
                state     <= S_WRITEBACK;
                mem_write <= 1'b1;
                mem_addr  <= {tag_arr[cpu_idx], cpu_idx, 2'b00};
                mem_wdata <= data_arr[cpu_idx];
              end else begin
                state    <= S_ALLOCATE;
                mem_read <= 1'b1;
                mem_addr <= {cpu_tag, cpu_idx, 2'b00};
              end
            end
          end
        end

        S_WRITEBACK: begin
          if (mem_ready) begin
            state     <= S_ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {lat_tag, lat_idx, 2'b00};
          end
        end

        S_ALLOCATE: begin
          if (mem_ready) begin
            // Fresh line is clean; a pending store merges on the next IDLE hit.
            state              <= S_IDLE;
            mem_read           <= 1'b0;
            data_arr[lat_idx]  <= mem_rdata;
            tag_arr[lat_idx]   <= lat_tag;
            valid_arr[lat_idx] <= 1'b1;
            dirty_arr[lat_idx] <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard bench for dm_cache_ctrl
module tb_dm_cache_ctrl;

  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_read;
  logic          cpu_write;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          stall;
  logic          hit;
  logic [LW-1:0] line_out;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;

  always #5 clk = ~clk;

  dm_cache_ctrl #(
    .CACHE_LINE_WIDTH(128),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .INDEX_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_read(cpu_read),
    .cpu_write(cpu_write),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .stall(stall),
    .hit(hit),
    .line_out(line_out),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  typedef struct packed {
    logic          hit;
    logic [LW-1:0] line;
  } cpu_exp_t;

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic          chk_wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  cpu_exp_t ce;
  mem_exp_t me;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [LW-1:0] L1  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [LW-1:0] L2  = 128'h44444444_DEADBEEF_22222222_11111111;
  localparam logic [LW-1:0] L3  = 128'h88888888_77777777_66666666_55555555;
  localparam logic [LW-1:0] L4  = 128'h00000004_00000003_00000002_00000001;
  localparam logic [LW-1:0] L4M = 128'h00000004_00000003_CAFEF00D_00000001;
  localparam logic [LW-1:0] L5  = 128'hBBBBBBBB_AAAAAAAA_99999999_12345678;
  localparam logic [LW-1:0] L6  = 128'h600DF00D_33333333_22222222_11111111;

  function automatic void check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_cpu(input logic h, input logic [LW-1:0] line);
    cpu_exp_t e;
    e.hit  = h;
    e.line = line;
    cpu_q.push_back(e);
  endfunction

  function automatic void push_mem(input logic wr, input logic rd, input logic [31:0] addr,
                                   input logic [LW-1:0] wdata, input logic chk);
    mem_exp_t e;
    e.wr        = wr;
    e.rd        = rd;
    e.addr      = addr;
    e.wdata     = wdata;
    e.chk_wdata = chk;
    mem_q.push_back(e);
  endfunction

  // Memory model: answers each request after a fixed number of cycles.
  int            lat_rd = 3;
  int            lat_wr = 2;
  int            rcnt   = 0;
  logic [LW-1:0] rd_line;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    #1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      rcnt      = 0;
    end
    if ((mem_read || mem_write) && !reset) begin
      rcnt++;
      if (rcnt == (mem_write ? lat_wr : lat_rd)) begin
        mem_ready = 1'b1;
        mem_rdata = rd_line;
      end
    end else begin
      rcnt = 0;
    end
  end

  // Monitor: pops an expectation whenever the DUT completes a CPU access or a memory transfer.
  always @(negedge clk) begin
    if (!reset) begin
      check("mem_rd_wr_exclusive", mem_read & mem_write, 0);
      if ((cpu_read || cpu_write) && !stall) begin
        if (cpu_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL cpu_unexpected: got completion at addr %h expected none", cpu_addr);
        end else begin
          ce = cpu_q.pop_front();
          check("cpu_hit", hit, ce.hit);
          check("cpu_line", line_out, ce.line);
        end
      end
      if (mem_ready && (mem_read || mem_write)) begin
        if (mem_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mem_unexpected: got transfer at %h expected none", mem_addr);
        end else begin
          me = mem_q.pop_front();
          check("mem_write", mem_write, me.wr);
          check("mem_read", mem_read, me.rd);
          check("mem_addr", mem_addr, me.addr);
          if (me.chk_wdata) check("mem_wdata", mem_wdata, me.wdata);
        end
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_first_hit, input int exp_cycles);
    int cyc  = 0;
    bit done = 0;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("first_hit", hit, exp_first_hit);
      if (!stall) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_timeout: got stall after %0d cycles expected release", cyc);
    end else begin
      check("latency", cyc, exp_cycles);
    end
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    rd_line   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_hit", hit, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_line_out", line_out, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Clean read miss then refill.
    rd_line = L1;
    push_mem(0, 1, 32'h10, '0, 0);
    push_cpu(1, L1);
    access(1, 0, 32'h10, 0, 0, 5);

    // Write hit to word 2, then read it back.
    push_cpu(1, L1);
    access(0, 1, 32'h12, 32'hDEADBEEF, 1, 1);
    push_cpu(1, L2);
    access(1, 0, 32'h12, 0, 1, 1);

    // Conflicting read with a dirty victim: writeback then allocate.
    rd_line = L3;
    push_mem(1, 0, 32'h10, L2, 1);
    push_mem(0, 1, 32'h30, '0, 0);
    push_cpu(1, L3);
    access(1, 0, 32'h32, 0, 0, 7);

    // Write miss on a clean line: allocate only, merge word 1.
    rd_line = L4;
    push_mem(0, 1, 32'h24, '0, 0);
    push_cpu(1, L4);
    access(0, 1, 32'h25, 32'hCAFEF00D, 0, 5);
    push_cpu(1, L4M);
    access(1, 0, 32'h25, 0, 1, 1);

    // Evicting that line proves the merge marked it dirty.
    rd_line = L5;
    push_mem(1, 0, 32'h24, L4M, 1);
    push_mem(0, 1, 32'h04, '0, 0);
    push_cpu(1, L5);
    access(1, 0, 32'h05, 0, 0, 7);

    // Reset in the middle of an allocate.
    rd_line   = L3;
    cpu_read  = 1'b1;
    cpu_addr  = 32'h40;
    @(negedge clk);
    check("abort_first_stall", stall, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_mem_read", mem_read, 1);
    check("abort_mem_addr", mem_addr, 32'h40);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    cpu_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_read_low", mem_read, 0);
    check("abort_mem_write_low", mem_write, 0);
    check("abort_mem_addr_clr", mem_addr, 0);
    check("abort_stall", stall, 0);
    check("abort_hit", hit, 0);
    @(posedge clk);
    #1;

    // Previously valid line now misses and refills clean.
    rd_line = L1;
    push_mem(0, 1, 32'h10, '0, 0);
    push_cpu(1, L1);
    access(1, 0, 32'h10, 0, 0, 5);

    // Read and write together on a hit acts as a write to word 3.
    push_cpu(1, L1);
    access(1, 1, 32'h13, 32'h600DF00D, 1, 1);
    push_cpu(1, L6);
    access(1, 0, 32'h13, 0, 1, 1);
    rd_line = L3;
    push_mem(1, 0, 32'h10, L6, 1);
    push_mem(0, 1, 32'h30, '0, 0);
    push_cpu(1, L3);
    access(1, 0, 32'h30, 0, 0, 7);

    repeat (3) @(posedge clk);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
